// File: rtl/mem_dbus_stage_pkg.sv
// ============================================================================
// mem_dbus_stage_pkg : shared op codes, exception codes, bus sizes, FSM states
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem_dbus_stage_pkg;

    localparam logic [7:0] OP_LB  = 8'h90;
    localparam logic [7:0] OP_LBU = 8'h91;
    localparam logic [7:0] OP_LH  = 8'h92;
    localparam logic [7:0] OP_LHU = 8'h93;
    localparam logic [7:0] OP_LW  = 8'h94;
    localparam logic [7:0] OP_SB  = 8'h98;
    localparam logic [7:0] OP_SH  = 8'h99;
    localparam logic [7:0] OP_SW  = 8'h9A;

    localparam logic [4:0] EXC_NONE = 5'h10;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    function automatic logic is_load(input logic [7:0] op);
        return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
               (op == OP_LHU) || (op == OP_LW);
    endfunction

    function automatic logic is_store(input logic [7:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic [1:0] op_size(input logic [7:0] op);
        case (op)
            OP_LH, OP_LHU, OP_SH: return SIZE_HALF;
            OP_LW, OP_SW:         return SIZE_WORD;
            default:              return SIZE_BYTE;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        return ((size == SIZE_HALF) && lo[0]) || ((size == SIZE_WORD) && (lo != 2'b00));
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_load_ext.sv
// ============================================================================
// mem_load_ext : byte/half lane select and sign/zero extension of load data
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_load_ext
    import mem_dbus_stage_pkg::*;
(
    input  logic [7:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] dout
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Little-endian lanes: byte address selects the lane within the word
    assign w_byte = rdata[{addr_lo, 3'b000} +: 8];
    assign w_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        dout = rdata;
        case (op)
            OP_LB:   dout = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  dout = {24'd0, w_byte};
            OP_LH:   dout = {{16{w_half[15]}}, w_half};
            OP_LHU:  dout = {16'd0, w_half};
            default: dout = rdata;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_dbus_stage.sv
// ============================================================================
// mem_dbus_stage : MEM-stage load/store decode, alignment check, data-bus FSM
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_dbus_stage
    import mem_dbus_stage_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
)(
    input  logic              cpu_clk_50M,
    input  logic              cpu_rst_n,
    input  logic [7:0]        mem_aluop,
    input  logic [31:0]       mem_wd,
    input  logic [31:0]       mem_din,
    input  logic              mem_mreg,
    input  logic [4:0]        mem_exccode,
    input  logic              flush,
    input  logic              stall_wb,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic [DATA_W-1:0] data_rdata,
    input  logic              data_data_ok,
    output logic              stall_req_mem,
    output logic [DATA_W-1:0] wb_dout,
    output logic              wb_dvalid,
    output logic [4:0]        wb_exccode
);

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_size;
    logic              r_wr;
    logic [DATA_W-1:0] r_wdata;
    logic [7:0]        r_op;
    logic [DATA_W-1:0] r_buf;

    logic              w_is_load, w_is_store, w_misalign, w_exc_ok, w_issue_ok;
    logic [1:0]        w_size;
    logic [DATA_W-1:0] w_wdata;
    logic [4:0]        w_exc;
    logic [7:0]        w_ext_op;
    logic [1:0]        w_ext_lo;
    logic [DATA_W-1:0] w_ext_dout;
    logic              w_issue, w_capture, w_bus_done;
    logic              w_unused;

    assign w_unused   = mem_mreg;
    assign w_is_load  = is_load(mem_aluop);
    assign w_is_store = is_store(mem_aluop);
    assign w_size     = op_size(mem_aluop);
    assign w_misalign = misaligned(w_size, mem_wd[1:0]);
    assign w_exc_ok   = (mem_exccode == EXC_NONE);
    assign w_issue_ok = (w_is_load || w_is_store) && w_exc_ok && !w_misalign && !flush;

    always_comb begin
        w_wdata = mem_din;
        case (w_size)
            SIZE_BYTE: w_wdata = {4{mem_din[7:0]}};
            SIZE_HALF: w_wdata = {2{mem_din[15:0]}};
            default:   w_wdata = mem_din;
        endcase
    end

    always_comb begin
        w_exc = mem_exccode;
        if (w_exc_ok && w_misalign && w_is_load)
            w_exc = EXC_ADEL;
        else if (w_exc_ok && w_misalign && w_is_store)
            w_exc = EXC_ADES;
    end

    // In the issuing cycle the registers are not loaded yet, so extend from the live fields
    assign w_ext_op = (r_state == ST_IDLE) ? mem_aluop   : r_op;
    assign w_ext_lo = (r_state == ST_IDLE) ? mem_wd[1:0] : r_addr[1:0];

    mem_load_ext u_load_ext (
        .op      (w_ext_op),
        .addr_lo (w_ext_lo),
        .rdata   (data_rdata),
        .dout    (w_ext_dout)
    );

    always_comb begin
        w_state_nxt   = r_state;
        data_req      = 1'b0;
        data_wr       = 1'b0;
        data_size     = SIZE_BYTE;
        data_addr     = '0;
        data_wdata    = '0;
        stall_req_mem = 1'b0;
        wb_dvalid     = 1'b0;
        wb_dout       = '0;
        wb_exccode    = w_exc;
        w_issue       = 1'b0;
        w_capture     = 1'b0;
        w_bus_done    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_issue_ok) begin
                    data_req      = 1'b1;
                    data_wr       = w_is_store;
                    data_size     = w_size;
                    data_addr     = mem_wd[ADDR_W-1:0];
                    data_wdata    = w_wdata;
                    stall_req_mem = 1'b1;
                    w_issue       = 1'b1;
                    if (data_addr_ok) begin
                        if (data_data_ok) w_bus_done  = 1'b1;
                        else              w_state_nxt = ST_WAIT;
                    end else begin
                        w_state_nxt = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                data_req      = 1'b1;
                data_wr       = r_wr;
                data_size     = r_size;
                data_addr     = r_addr;
                data_wdata    = r_wdata;
                stall_req_mem = 1'b1;
                if (data_addr_ok) begin
                    if (data_data_ok) w_bus_done  = 1'b1;
                    else if (flush)   w_state_nxt = ST_DRAIN;
                    else              w_state_nxt = ST_WAIT;
                end else if (flush) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                stall_req_mem = 1'b1;
                if (data_data_ok) w_bus_done  = 1'b1;
                else if (flush)   w_state_nxt = ST_DRAIN;
            end
            ST_DONE: begin
                wb_dvalid = 1'b1;
                wb_dout   = r_buf;
                if (!stall_wb) w_state_nxt = ST_IDLE;
            end
            ST_DRAIN: begin
                stall_req_mem = 1'b1;
                if (data_data_ok) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // Completion; a flush in the same cycle discards the returned data
        if (w_bus_done) begin
            stall_req_mem = 1'b0;
            w_state_nxt   = ST_IDLE;
            if (!flush && is_load(w_ext_op)) begin
                if (stall_wb) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_DONE;
                end else begin
                    wb_dvalid = 1'b1;
                    wb_dout   = w_ext_dout;
                end
            end
        end

        if (cpu_rst_n) begin
            data_req      = 1'b0;
            data_wr       = 1'b0;
            data_size     = SIZE_BYTE;
            data_addr     = '0;
            data_wdata    = '0;
            stall_req_mem = 1'b0;
            wb_dvalid     = 1'b0;
            wb_dout       = '0;
            wb_exccode    = EXC_NONE;
            w_issue       = 1'b0;
            w_capture     = 1'b0;
        end
    end

    always_ff @(posedge cpu_clk_50M or posedge cpu_rst_n) begin
        if (cpu_rst_n) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_size  <= SIZE_BYTE;
            r_wr    <= 1'b0;
            r_wdata <= '0;
            r_op    <= '0;
            r_buf   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_issue) begin
                r_addr  <= mem_wd[ADDR_W-1:0];
                r_size  <= w_size;
                r_wr    <= w_is_store;
                r_wdata <= w_wdata;
                r_op    <= mem_aluop;
            end
            if (w_capture)
                r_buf <= w_ext_dout;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_dbus_stage.sv
// ============================================================================
// tb_mem_dbus_stage : directed vector table plus multi-cycle bus sequences
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_dbus_stage;
    import mem_dbus_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  aluop;
    logic [31:0] wd, din, rdata;
    logic        mreg, flush, stall_wb, addr_ok, data_ok;
    logic [4:0]  exc;
    logic        req, wr, stall, dvalid;
    logic [1:0]  size;
    logic [31:0] addr, wdata, dout;
    logic [4:0]  wexc;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    mem_dbus_stage dut (
        .cpu_clk_50M   (clk),
        .cpu_rst_n     (rst),
        .mem_aluop     (aluop),
        .mem_wd        (wd),
        .mem_din       (din),
        .mem_mreg      (mreg),
        .mem_exccode   (exc),
        .flush         (flush),
        .stall_wb      (stall_wb),
        .data_req      (req),
        .data_wr       (wr),
        .data_size     (size),
        .data_addr     (addr),
        .data_wdata    (wdata),
        .data_addr_ok  (addr_ok),
        .data_rdata    (rdata),
        .data_data_ok  (data_ok),
        .stall_req_mem (stall),
        .wb_dout       (dout),
        .wb_dvalid     (dvalid),
        .wb_exccode    (wexc)
    );

    typedef struct {
        logic [7:0]  op;
        logic [31:0] wd;
        logic [31:0] din;
        logic [4:0]  exc;
        logic        flush;
        logic        aok;
        logic        dok;
        logic [31:0] rdata;
        logic        e_req;
        logic        e_wr;
        logic [1:0]  e_size;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_stall;
        logic        e_dvalid;
        logic [31:0] e_dout;
        logic [4:0]  e_exc;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            passed++;
    endtask

    task automatic idle_inputs();
        aluop = 8'h00; wd = '0; din = '0; exc = EXC_NONE; flush = 1'b0;
        stall_wb = 1'b0; addr_ok = 1'b0; data_ok = 1'b0; rdata = '0; mreg = 1'b1;
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        //        op      wd          din          exc       fl   aok   dok   rdata        req  wr  sz  addr        wdata        stl  dv   dout         wexc
        vecs[0]  = '{OP_LW,  32'h100, 32'h0,        EXC_NONE, 1'b0, 1'b1, 1'b1, 32'h800000F0, 1'b1, 1'b0, 2'd2, 32'h100, 32'h0,        1'b0, 1'b1, 32'h800000F0, EXC_NONE};
        vecs[1]  = '{OP_SH,  32'h202, 32'h1234ABCD, EXC_NONE, 1'b0, 1'b1, 1'b1, 32'h0,        1'b1, 1'b1, 2'd1, 32'h202, 32'hABCDABCD, 1'b0, 1'b0, 32'h0,        EXC_NONE};
        vecs[2]  = '{OP_LH,  32'h101, 32'h0,        EXC_NONE, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 2'd0, 32'h0,   32'h0,        1'b0, 1'b0, 32'h0,        EXC_ADEL};
        vecs[3]  = '{OP_SW,  32'h102, 32'h55,       EXC_NONE, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 2'd0, 32'h0,   32'h0,        1'b0, 1'b0, 32'h0,        EXC_ADES};
        vecs[4]  = '{OP_SB,  32'h003, 32'h000000A5, EXC_NONE, 1'b0, 1'b1, 1'b1, 32'h0,        1'b1, 1'b1, 2'd0, 32'h003, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h0,        EXC_NONE};
        vecs[5]  = '{OP_LBU, 32'h002, 32'h0,        EXC_NONE, 1'b0, 1'b1, 1'b1, 32'h11AB2233, 1'b1, 1'b0, 2'd0, 32'h002, 32'h0,        1'b0, 1'b1, 32'h000000AB, EXC_NONE};
        vecs[6]  = '{OP_LH,  32'h002, 32'h0,        EXC_NONE, 1'b0, 1'b1, 1'b1, 32'h87651234, 1'b1, 1'b0, 2'd1, 32'h002, 32'h0,        1'b0, 1'b1, 32'hFFFF8765, EXC_NONE};
        vecs[7]  = '{OP_LB,  32'h001, 32'h0,        EXC_NONE, 1'b0, 1'b1, 1'b1, 32'h00007F00, 1'b1, 1'b0, 2'd0, 32'h001, 32'h0,        1'b0, 1'b1, 32'h0000007F, EXC_NONE};
        vecs[8]  = '{8'h00,  32'h100, 32'h0,        5'h0A,    1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 2'd0, 32'h0,   32'h0,        1'b0, 1'b0, 32'h0,        5'h0A};
        vecs[9]  = '{OP_LW,  32'h104, 32'h0,        5'h0A,    1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 2'd0, 32'h0,   32'h0,        1'b0, 1'b0, 32'h0,        5'h0A};
        vecs[10] = '{OP_LH,  32'h101, 32'h0,        5'h0A,    1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 2'd0, 32'h0,   32'h0,        1'b0, 1'b0, 32'h0,        5'h0A};
        vecs[11] = '{OP_LW,  32'h108, 32'h0,        EXC_NONE, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 2'd0, 32'h0,   32'h0,        1'b0, 1'b0, 32'h0,        EXC_NONE};
        vecs[12] = '{OP_SW,  32'h10C, 32'hDEADBEEF, EXC_NONE, 1'b0, 1'b1, 1'b1, 32'h0,        1'b1, 1'b1, 2'd2, 32'h10C, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0,        EXC_NONE};

        // Reset state, with a valid op present on the inputs
        idle_inputs();
        aluop = OP_LW; wd = 32'h100;
        rst = 1'b1;
        cyc(); settle();
        chk("rst_req", {31'd0, req}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_dvalid", {31'd0, dvalid}, 32'd0);
        chk("rst_addr", addr, 32'd0);
        chk("rst_exc", {27'd0, wexc}, {27'd0, EXC_NONE});
        cyc(); rst = 1'b0; idle_inputs();
        settle();
        chk("idle_req", {31'd0, req}, 32'd0);

        // Single-cycle vectors, each ending back in IDLE
        for (int i = 0; i < 13; i++) begin
            cyc();
            idle_inputs();
            aluop = vecs[i].op; wd = vecs[i].wd; din = vecs[i].din; exc = vecs[i].exc;
            flush = vecs[i].flush; addr_ok = vecs[i].aok; data_ok = vecs[i].dok;
            rdata = vecs[i].rdata;
            settle();
            chk($sformatf("v%0d_req", i),    {31'd0, req},    {31'd0, vecs[i].e_req});
            chk($sformatf("v%0d_wr", i),     {31'd0, wr},     {31'd0, vecs[i].e_wr});
            chk($sformatf("v%0d_size", i),   {30'd0, size},   {30'd0, vecs[i].e_size});
            chk($sformatf("v%0d_addr", i),   addr,            vecs[i].e_addr);
            chk($sformatf("v%0d_wdata", i),  wdata,           vecs[i].e_wdata);
            chk($sformatf("v%0d_stall", i),  {31'd0, stall},  {31'd0, vecs[i].e_stall});
            chk($sformatf("v%0d_dvalid", i), {31'd0, dvalid}, {31'd0, vecs[i].e_dvalid});
            chk($sformatf("v%0d_dout", i),   dout,            vecs[i].e_dout);
            chk($sformatf("v%0d_exc", i),    {27'd0, wexc},   {27'd0, vecs[i].e_exc});
        end

        // LB 0x103: addr_ok two cycles late, data_ok three cycles after that
        cyc(); idle_inputs(); aluop = OP_LB; wd = 32'h103; settle();
        chk("lb_c0_stall", {31'd0, stall}, 32'd1);
        chk("lb_c0_addr", addr, 32'h103);
        cyc(); settle();
        chk("lb_c1_req", {31'd0, req}, 32'd1);
        chk("lb_c1_addr", addr, 32'h103);
        chk("lb_c1_stall", {31'd0, stall}, 32'd1);
        cyc(); addr_ok = 1'b1; settle();
        chk("lb_c2_req", {31'd0, req}, 32'd1);
        chk("lb_c2_addr", addr, 32'h103);
        chk("lb_c2_size", {30'd0, size}, 32'd0);
        chk("lb_c2_stall", {31'd0, stall}, 32'd1);
        cyc(); addr_ok = 1'b0; settle();
        chk("lb_c3_req", {31'd0, req}, 32'd0);
        chk("lb_c3_stall", {31'd0, stall}, 32'd1);
        cyc(); settle();
        chk("lb_c4_stall", {31'd0, stall}, 32'd1);
        cyc(); data_ok = 1'b1; rdata = 32'h80000000; settle();
        chk("lb_c5_stall", {31'd0, stall}, 32'd0);
        chk("lb_c5_dvalid", {31'd0, dvalid}, 32'd1);
        chk("lb_c5_dout", dout, 32'hFFFFFF80);
        cyc(); idle_inputs(); settle();
        chk("lb_c6_dvalid", {31'd0, dvalid}, 32'd0);
        chk("lb_c6_stall", {31'd0, stall}, 32'd0);

        // LW flushed after addr_ok: drain, new op blocked, data discarded
        cyc(); aluop = OP_LW; wd = 32'h200; addr_ok = 1'b1; settle();
        chk("dr_c0_stall", {31'd0, stall}, 32'd1);
        cyc(); addr_ok = 1'b0; flush = 1'b1; settle();
        chk("dr_c1_stall", {31'd0, stall}, 32'd1);
        cyc(); idle_inputs(); settle();
        chk("dr_c2_stall", {31'd0, stall}, 32'd1);
        cyc(); aluop = OP_LW; wd = 32'h300; settle();
        chk("dr_c3_req", {31'd0, req}, 32'd0);
        cyc(); settle();
        chk("dr_c4_req", {31'd0, req}, 32'd0);
        chk("dr_c4_stall", {31'd0, stall}, 32'd1);
        cyc(); idle_inputs(); data_ok = 1'b1; rdata = 32'h12345678; settle();
        chk("dr_c5_dvalid", {31'd0, dvalid}, 32'd0);
        chk("dr_c5_stall", {31'd0, stall}, 32'd1);
        cyc(); idle_inputs(); settle();
        chk("dr_c6_stall", {31'd0, stall}, 32'd0);

        // LHU with stall_wb held two cycles: DONE holds the extended word
        cyc(); aluop = OP_LHU; wd = 32'h0; addr_ok = 1'b1; data_ok = 1'b1;
        rdata = 32'hFFFF8001; stall_wb = 1'b1; settle();
        chk("st_c0_dvalid", {31'd0, dvalid}, 32'd0);
        chk("st_c0_stall", {31'd0, stall}, 32'd0);
        cyc(); addr_ok = 1'b0; data_ok = 1'b0; rdata = 32'h0; settle();
        chk("st_c1_dvalid", {31'd0, dvalid}, 32'd1);
        chk("st_c1_dout", dout, 32'h00008001);
        chk("st_c1_req", {31'd0, req}, 32'd0);
        cyc(); stall_wb = 1'b0; settle();
        chk("st_c2_dvalid", {31'd0, dvalid}, 32'd1);
        chk("st_c2_dout", dout, 32'h00008001);
        cyc(); idle_inputs(); settle();
        chk("st_c3_dvalid", {31'd0, dvalid}, 32'd0);

        // Flush together with data_ok in WAIT: data discarded, back to IDLE
        cyc(); aluop = OP_LW; wd = 32'h400; addr_ok = 1'b1; settle();
        cyc(); addr_ok = 1'b0; flush = 1'b1; data_ok = 1'b1; rdata = 32'hCAFEF00D; settle();
        chk("fd_dvalid", {31'd0, dvalid}, 32'd0);
        cyc(); idle_inputs(); settle();
        chk("fd_next_stall", {31'd0, stall}, 32'd0);

        // Withdrawal in REQ: req still high in the flush cycle, low afterwards
        cyc(); aluop = OP_SW; wd = 32'h500; din = 32'h1; settle();
        cyc(); flush = 1'b1; settle();
        chk("wd_flush_req", {31'd0, req}, 32'd1);
        cyc(); idle_inputs(); settle();
        chk("wd_next_req", {31'd0, req}, 32'd0);
        chk("wd_next_stall", {31'd0, stall}, 32'd0);

        // Asynchronous reset while in WAIT
        cyc(); aluop = OP_LW; wd = 32'h600; addr_ok = 1'b1; settle();
        cyc(); addr_ok = 1'b0; settle();
        chk("ar_wait_stall", {31'd0, stall}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("ar_rst_stall", {31'd0, stall}, 32'd0);
        chk("ar_rst_req", {31'd0, req}, 32'd0);
        cyc(); rst = 1'b0; addr_ok = 1'b1; data_ok = 1'b1; rdata = 32'h00000005; settle();
        chk("ar_idle_req", {31'd0, req}, 32'd1);
        chk("ar_idle_dvalid", {31'd0, dvalid}, 32'd1);
        chk("ar_idle_dout", dout, 32'h00000005);
        cyc(); idle_inputs(); settle();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire
